counter_ctrl: RTL

Sequencing controller directly upstream of the 4-bit JK synchronous counter. It converts start/stop/load commands into the counter's `cn_en`, `clear` and `preset` controls. In one-shot mode it watches the counter output `q` and halts counting exactly at a programmable limit. In free-run mode it flags each wrap-around.

---
 rtl/counter_ctrl_pkg.sv | 20 ++
 rtl/counter_ctrl_pulse_timer.sv | 28 ++
 rtl/counter_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
package counter_ctrl_pkg;

  // Default width of the counter value and the terminal limit.
  localparam int unsigned DefWidth = 4;

  // All-ones counter value; this is the preset target and the pre-wrap value.
  localparam logic [DefWidth-1:0] AllOnes = '1;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StClr,
    StRun,
    StHold,
    StDone
  } state_e;

endpackage

// File: rtl/counter_ctrl_pulse_timer.sv
// Loadable down-counter that times the cnt_clear / cnt_preset pulse width.
// After a load of N, o_expired stays low for N cycles and then rises.
module counter_ctrl_pulse_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          i_clk,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_expired
);

  logic [TW-1:0] r_cnt;

  // Load on pulse entry, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for a falling-edge synchronous counter: turns start/stop/load
// commands into registered cn_en/cnt_clear/cnt_preset, halts exactly at a limit in
// one-shot mode and flags all-ones -> zero wraps in free-run mode.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned PULSE = 2
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_load,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_lim,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_cn_en,
  output logic             o_cnt_clear,
  output logic             o_cnt_preset,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap
);

  localparam int unsigned     TimerW    = 4;
  // The timer expires PULSE-1 edges after the load, giving PULSE high cycles.
  localparam logic [TimerW-1:0] PulseLoad = TimerW'(PULSE - 1);
  localparam logic [WIDTH-1:0]  Ones      = {WIDTH{1'b1}};

  state_e           r_state;
  state_e           w_state_d;
  state_e           w_resume_state;
  logic [WIDTH-1:0] r_lim;
  logic             r_mode;
  logic [WIDTH-1:0] r_prev_q;
  logic             w_capture;
  logic             w_hit;
  logic             w_timer_load;
  logic             w_expired;

  logic             r_cn_en;
  logic             r_cnt_clear;
  logic             r_cnt_preset;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;
  logic             w_wrap_d;

  // One-shot terminal condition on the q sampled at this edge.
  assign w_hit = !r_mode && (i_q == r_lim);

  // Entering RUN is also gated by the limit, so lim already reached (e.g. lim=0 after
  // the clear pulse, or a stop landing on the limit) never issues a count.
  assign w_resume_state = w_hit ? StDone : StRun;

  // Restart the pulse timer on every entry into PRE or CLR.
  assign w_timer_load = ((w_state_d == StPre) && (r_state != StPre)) ||
                        ((w_state_d == StClr) && (r_state != StClr));

  assign w_wrap_d = (r_prev_q == Ones) && (i_q == '0) && (r_state == StRun);

  counter_ctrl_pulse_timer #(
    .TW (TimerW)
  ) u_pulse_timer (
    .i_clk      (i_clk),
    .i_clear    (i_clear),
    .i_load     (w_timer_load),
    .i_load_val (PulseLoad),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode; stop outranks load, which outranks start.
  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    case (r_state)
      StIdle: begin
        // A stop in IDLE is a no-op but still masks load/start in the same cycle.
        if (!i_stop) begin
          if (i_load) begin
            w_state_d = StPre;
          end else if (i_start) begin
            w_state_d = StClr;
            w_capture = 1'b1;
          end
        end
      end
      StPre: begin
        if (i_stop || w_expired) begin
          w_state_d = StIdle;
        end
      end
      StClr: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (w_expired) begin
          w_state_d = w_resume_state;
        end
      end
      StRun: begin
        if (i_stop) begin
          w_state_d = StHold;
        end else if (w_hit) begin
          w_state_d = StDone;
        end
      end
      StHold: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (i_start) begin
          w_state_d = w_resume_state;
        end
      end
      StDone: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (i_start) begin
          w_state_d = StClr;
          w_capture = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Capture limit and mode on an accepted start.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_lim  <= '0;
      r_mode <= 1'b0;
    end else if (w_capture) begin
      r_lim  <= i_lim;
      r_mode <= i_mode;
    end
  end

  // Previous q for wrap detection.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_prev_q <= '0;
    end else begin
      r_prev_q <= i_q;
    end
  end

  // Outputs registered from the next state so commands show up one edge later.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_cn_en      <= 1'b0;
      r_cnt_clear  <= 1'b0;
      r_cnt_preset <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_cn_en      <= (w_state_d == StRun);
      r_cnt_clear  <= (w_state_d == StClr);
      r_cnt_preset <= (w_state_d == StPre);
      r_busy       <= (w_state_d == StPre) || (w_state_d == StClr) ||
                      (w_state_d == StRun) || (w_state_d == StHold);
      r_done       <= (w_state_d == StDone);
      r_wrap       <= w_wrap_d;
    end
  end

  assign o_cn_en      = r_cn_en;
  assign o_cnt_clear  = r_cnt_clear;
  assign o_cnt_preset = r_cnt_preset;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_wrap       = r_wrap;

endmodule
